// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: state encoding, BCD digit limits and time record shared by the timer.
// Rev 1.0
`default_nettype none

package countdown_timer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam logic [3:0] SEC0_MAX = 4'd9;
  localparam logic [3:0] SEC1_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

endpackage

`default_nettype wire

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: load/control inputs and remaining-time/status outputs of the timer.
// Rev 1.0
`default_nettype none

interface countdown_timer_if;
  import countdown_timer_pkg::*;

  logic       load;
  logic [3:0] load_m0;
  logic [3:0] load_s1;
  logic [3:0] load_s0;
  logic       count;
  logic       clear;
  logic [3:0] seconds0;
  logic [3:0] seconds1;
  logic [3:0] minutes0;
  logic       running;
  logic       done;
  logic       load_err;

  modport master (
    output load, load_m0, load_s1, load_s0, count, clear,
    input  seconds0, seconds1, minutes0, running, done, load_err
  );

  modport slave (
    input  load, load_m0, load_s1, load_s0, count, clear,
    output seconds0, seconds1, minutes0, running, done, load_err
  );

endinterface

`default_nettype wire

// File: rtl/countdown_timer_sec_prescaler.sv
// sec_prescaler: divides clk down to a one-cycle tick every TICKS_PER_SECOND enabled cycles.
// Rev 1.0
`default_nettype none

module sec_prescaler #(
  parameter int TICKS_PER_SECOND = 50_000_000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic enable,
  input  wire logic restart,
  output logic      tick
);

  localparam int             W      = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [W-1:0]   c_TERM = W'(TICKS_PER_SECOND - 1);

  logic [W-1:0] r_cnt;

  assign tick = enable && (r_cnt == c_TERM);

  // Holding the count while disabled keeps a partial second across a pause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= tick ? '0 : r_cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/countdown_timer.sv
// countdown_timer: loads m0:s1s0 in BCD and counts down once per second to 0:00, then flags done.
// Rev 1.0
`default_nettype none

module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICKS_PER_SECOND = 50_000_000,
  parameter int MAX_MINUTES      = 9
) (
  input  wire logic          clk,
  input  wire logic          reset,
  countdown_timer_if.slave   bus
);

  localparam logic [3:0] c_MIN_MAX = 4'(MAX_MINUTES);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  bcd_time_t  r_time;
  bcd_time_t  w_time_nxt;
  bcd_time_t  w_time_dec;
  logic       r_running;
  logic       r_done;
  logic       r_load_err;
  logic       w_done_nxt;
  logic       w_err_nxt;
  logic       w_load_ok;
  logic       w_enable;
  logic       w_restart;
  logic       w_tick;

  assign w_load_ok = (bus.load_s0 <= SEC0_MAX) && (bus.load_s1 <= SEC1_MAX) &&
                     (bus.load_m0 <= c_MIN_MAX);

  // Any load (valid or not) or clear in a cycle suppresses the tick of that cycle.
  assign w_enable  = (r_state == ST_RUN) && bus.count && !bus.load && !bus.clear;
  assign w_restart = bus.clear || (bus.load && w_load_ok);

  sec_prescaler #(
    .TICKS_PER_SECOND (TICKS_PER_SECOND)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (w_enable),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_comb begin
    w_time_dec = r_time;
    if (r_time.s0 != 4'd0) begin
      w_time_dec.s0 = r_time.s0 - 4'd1;
    end else begin
      w_time_dec.s0 = SEC0_MAX;
      if (r_time.s1 != 4'd0) begin
        w_time_dec.s1 = r_time.s1 - 4'd1;
      end else begin
        w_time_dec.s1 = SEC1_MAX;
        w_time_dec.m0 = r_time.m0 - 4'd1;
      end
    end
  end

  // RUN is only ever entered with a non-zero time, so a tick never sees 0:00.
  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (bus.clear) begin
      w_state_nxt = ST_IDLE;
      w_time_nxt  = '0;
    end else if (bus.load) begin
      if (w_load_ok) begin
        w_state_nxt = ST_IDLE;
        w_time_nxt  = '{m0: bus.load_m0, s1: bus.load_s1, s0: bus.load_s0};
      end else begin
        w_err_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.count && (r_time != '0)) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!bus.count) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_tick) begin
            w_time_nxt = w_time_dec;
            if (w_time_dec == '0) begin
              w_state_nxt = ST_EXPIRED;
              w_done_nxt  = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.count) w_state_nxt = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_time     <= '0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_time     <= w_time_nxt;
      r_running  <= (w_state_nxt == ST_RUN);
      r_done     <= w_done_nxt;
      r_load_err <= w_err_nxt;
    end
  end

  assign bus.seconds0 = r_time.s0;
  assign bus.seconds1 = r_time.s1;
  assign bus.minutes0 = r_time.m0;
  assign bus.running  = r_running;
  assign bus.done     = r_done;
  assign bus.load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and random stimulus, per-cycle scoreboard against a seconds-based model.
// Rev 1.0
`default_nettype none

module tb_countdown_timer;

  localparam int TPS   = 4;
  localparam int MAX_M = 7;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  countdown_timer_if bus();

  countdown_timer #(
    .TICKS_PER_SECOND (TPS),
    .MAX_MINUTES      (MAX_M)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXPIRED} mode_e;

  mode_e       m_mode  = M_IDLE;
  int          m_rem   = 0;
  int          m_phase = 0;
  logic [14:0] sb[$];
  int          checks    = 0;
  int          errors    = 0;
  int          done_seen = 0;

  function automatic logic [14:0] pack_exp(int rem, bit run, bit dn, bit er);
    logic [3:0] m, t, u;
    m = 4'(rem / 60);
    t = 4'((rem % 60) / 10);
    u = 4'(rem % 10);
    return {m, t, u, run, dn, er};
  endfunction

  function automatic logic [14:0] actual();
    return {bus.minutes0, bus.seconds1, bus.seconds0, bus.running, bus.done, bus.load_err};
  endfunction

  // Reference: remaining time kept as a plain count of seconds, one step per clock edge.
  task automatic model_step();
    bit dn = 1'b0;
    bit er = 1'b0;
    if (bus.clear) begin
      m_rem = 0; m_mode = M_IDLE; m_phase = 0;
    end else if (bus.load) begin
      if (int'(bus.load_s0) <= 9 && int'(bus.load_s1) <= 5 && int'(bus.load_m0) <= MAX_M) begin
        m_rem   = 60 * int'(bus.load_m0) + 10 * int'(bus.load_s1) + int'(bus.load_s0);
        m_mode  = M_IDLE;
        m_phase = 0;
      end else begin
        er = 1'b1;
      end
    end else begin
      case (m_mode)
        M_IDLE:  if (bus.count && m_rem > 0) m_mode = M_RUN;
        M_RUN: begin
          if (!bus.count) begin
            m_mode = M_PAUSE;
          end else if (m_phase == TPS - 1) begin
            m_phase = 0;
            m_rem   = m_rem - 1;
            if (m_rem == 0) begin
              m_mode = M_EXPIRED;
              dn     = 1'b1;
            end
          end else begin
            m_phase = m_phase + 1;
          end
        end
        M_PAUSE: if (bus.count) m_mode = M_RUN;
        default: ;
      endcase
    end
    sb.push_back(pack_exp(m_rem, m_mode == M_RUN, dn, er));
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_mode = M_IDLE; m_rem = 0; m_phase = 0;
        sb.delete();
      end else begin
        model_step();
      end
    end
  end

  initial begin
    logic [14:0] exp_v;
    logic [14:0] act_v;
    forever begin
      @(negedge clk);
      if (bus.done) done_seen = done_seen + 1;
      if (sb.size() > 0) begin
        exp_v  = sb.pop_front();
        act_v  = actual();
        checks = checks + 1;
        if (act_v !== exp_v) begin
          errors = errors + 1;
          $display("FAIL scoreboard t=%0t got m0=%0d s1=%0d s0=%0d run=%b done=%b err=%b want m0=%0d s1=%0d s0=%0d run=%b done=%b err=%b",
                   $time, act_v[14:11], act_v[10:7], act_v[6:3], act_v[2], act_v[1], act_v[0],
                   exp_v[14:11], exp_v[10:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(int m, int t, int u);
    bus.load_m0 = 4'(m);
    bus.load_s1 = 4'(t);
    bus.load_s0 = 4'(u);
    bus.load    = 1'b1;
    cyc(1);
    bus.load    = 1'b0;
  endtask

  task automatic check_now(string name, logic [14:0] want);
    logic [14:0] got;
    got    = actual();
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    int d0;
    int r;
    bus.load = 1'b0; bus.clear = 1'b0; bus.count = 1'b0;
    bus.load_m0 = 4'd0; bus.load_s1 = 4'd0; bus.load_s0 = 4'd0;

    reset = 1'b0;
    cyc(2);
    check_now("reset_state", 15'd0);
    reset = 1'b1;
    cyc(1);

    // 1:05 down through the minute borrow: six ticks after RUN entry gives 0:59.
    bus.count = 1'b1;
    do_load(1, 0, 5);
    cyc(25);
    check_now("borrow_0_59", {4'd0, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0});

    // Expiry from 0:02 and a long hold at 0:00 with count still high.
    do_load(0, 0, 2);
    d0 = done_seen;
    cyc(29);
    checks = checks + 1;
    if (done_seen - d0 != 1) begin
      errors = errors + 1;
      $display("FAIL done_pulses got %0d want 1", done_seen - d0);
    end
    check_now("expired_hold", 15'd0);

    // Pause part-way through a second; the kept partial second shortens the next one.
    do_load(0, 3, 0);
    cyc(3);
    bus.count = 1'b0;
    cyc(10);
    bus.count = 1'b1;
    cyc(8);

    // Out-of-range loads while running.
    do_load(0, 6, 0);
    do_load(0, 0, 10);
    do_load(MAX_M + 1, 0, 0);
    cyc(3);

    // Load landing exactly on the tick cycle, then clear together with load.
    do_load(0, 4, 0);
    cyc(4);
    do_load(0, 4, 5);
    check_now("load_beats_tick", {4'd0, 4'd4, 4'd5, 1'b0, 1'b0, 1'b0});
    cyc(3);
    bus.clear = 1'b1;
    do_load(3, 2, 1);
    bus.clear = 1'b0;
    check_now("clear_beats_load", 15'd0);
    cyc(2);

    // Asynchronous reset between edges while running.
    do_load(0, 5, 0);
    cyc(3);
    #1 reset = 1'b0;
    #1 check_now("async_reset", 15'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    cyc(5);
    check_now("idle_after_reset", 15'd0);

    repeat (600) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        bus.clear = 1'b1;
      end
      if (r >= 2 && r < 12) begin
        bus.load_m0 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
        bus.load_s1 = 4'($urandom_range(0, 6));
        bus.load_s0 = 4'($urandom_range(0, 10));
        bus.load    = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) bus.count = ~bus.count;
      cyc(1);
      bus.clear = 1'b0;
      bus.load  = 1'b0;
    end

    cyc(1);
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
